// File: rtl/axis_frame_packer_pkg.sv
// Shared definitions for the frame packer: state encoding and counter sizing.
package axis_frame_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } pack_state_t;

  // Counter width for n slots, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_frame_packer.sv
// Collects a raster pixel stream into one flattened frame word and offers it
// on an AXI-Stream master port; framing errors raise a one-cycle pulse.
module axis_frame_packer
  import axis_frame_packer_pkg::*;
#(
  parameter int unsigned R_I = 5,
  parameter int unsigned C_I = 5,
  parameter int unsigned W_I = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic                     s_axis_pixel_ready,
  input  logic                     s_axis_pixel_valid,
  input  logic [W_I-1:0]           s_axis_pixel_data,
  input  logic                     s_axis_pixel_last,
  input  logic                     m_axis_frame_ready,
  output logic                     m_axis_frame_valid,
  output logic [R_I*C_I*W_I-1:0]   m_axis_frame_data,
  output logic                     frame_err
);

  localparam int unsigned N_PIX = R_I * C_I;
  localparam int unsigned CNT_W = cnt_width(N_PIX);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_PIX - 1);

  pack_state_t            state;
  logic [CNT_W-1:0]       cnt;
  logic [N_PIX*W_I-1:0]   frame_buf;
  logic                   accept;
  logic                   at_last_slot;
  logic                   early_last;

  assign s_axis_pixel_ready = (state == FILL);
  assign accept             = s_axis_pixel_valid & s_axis_pixel_ready;
  assign at_last_slot       = (cnt == LAST_SLOT);
  assign early_last         = s_axis_pixel_last & ~at_last_slot;
  assign m_axis_frame_data  = frame_buf;

  // Control FSM: pixel count, fill/send state, registered valid and error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= FILL;
      cnt                <= '0;
      m_axis_frame_valid <= 1'b0;
      frame_err          <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (at_last_slot) begin
              cnt                <= '0;
              state              <= SEND;
              m_axis_frame_valid <= 1'b1;
              frame_err          <= ~s_axis_pixel_last;
            end else if (s_axis_pixel_last) begin
              cnt       <= '0;
              frame_err <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        SEND: begin
          if (m_axis_frame_ready) begin
            state              <= FILL;
            m_axis_frame_valid <= 1'b0;
          end
        end
        default: begin
          state              <= FILL;
          m_axis_frame_valid <= 1'b0;
        end
      endcase
    end
  end

  // Frame buffer: accepted pixel lands in slot cnt; an early-last beat is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_buf <= '0;
    end else if (accept && !early_last) begin
      for (int unsigned k = 0; k < N_PIX; k++) begin
        if (cnt == CNT_W'(k)) begin
          frame_buf[k*W_I +: W_I] <= s_axis_pixel_data;
        end
      end
    end
  end

endmodule
